temporizador_multi: RTL and testbench
=====================================

# temporizador_multi

Multi-channel, parametrised successor of the single one-shot second timer in the tamagotchi core. A single shared prescaler divides `clk` into a base tick (1 s at 50 MHz by default). CH independent channels count that tick down from a per-channel load value, in one-shot or periodic mode. Game logic uses it for hunger, sleep, play and animation timers without instantiating one full-width counter per timer.

## Interface
- `TICK_DIV`, default 50000000: clk cycles per base tick; must be ≥ 2.
- `CH`, default 4: number of channels.
- `CNT_W`, default 16: width of each channel's tick count.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input CH: per-channel load-and-run request, level-sampled each cycle.
- `stop` input CH: per-channel abort request.
- `periodic` input CH: mode, sampled with `start`. 1 = auto-reload, 0 = one-shot.
- `load_val` input CH*CNT_W: channel i count is `load_val[i*CNT_W +: CNT_W]`, sampled with `start`.
- `tick` output 1: one-cycle pulse at every base tick.
- `busy` output CH: channel is in the RUN state.
- `done` output CH: one-cycle pulse when a channel expires.
- `remaining` output CH*CNT_W: current count per channel, packed the same way as `load_val`.

## Operation
**Reset**
- While `rst_n` is low: prescaler = 0, `tick` = 0, every channel IDLE, `busy` = 0, `done` = 0, `remaining` = 0, latched reload values = 0, latched modes = 0.

**Prescaler**
- Width is `$clog2(TICK_DIV)`.
- Free-running: counts 0..TICK_DIV-1, then wraps to 0.
- `tick` is registered and is high for exactly the cycle after the counter equals TICK_DIV-1.
- Shared by all channels. It is never restarted by `start`.

**Channel FSM, per channel, evaluated in priority order each cycle**
1. `stop`: go to IDLE and clear `remaining` to 0. No `done`. Applies in any state and wins over `start`.
2. `start` with `load_val` = 0: stay in or return to IDLE, `remaining` = 0, pulse `done` next cycle.
3. `start` with `load_val` ≠ 0: latch `load_val` and `periodic`, set `remaining` = `load_val`, enter RUN. Valid from IDLE or RUN; from RUN it is a restart. A `start` in the same cycle as an expiring tick wins: it reloads and suppresses that cycle's `done`.
4. RUN and `tick` and `remaining` > 1: decrement `remaining`.
5. RUN and `tick` and `remaining` = 1: pulse `done`. If the latched mode is periodic, reload `remaining` from the latched value and stay in RUN. Otherwise set `remaining` = 0 and go to IDLE.
6. Any other case: hold.

**Other rules**
- `done`, `busy` and `remaining` are registered.
- `done` is high for exactly one cycle per expiry.
- Changing `load_val` or `periodic` while a channel is running has no effect until the next `start`.
- Count arithmetic is unsigned CNT_W bits. The count never wraps, because reaching 1 always ends or reloads the count.
- Channels are fully independent; any combination of channels may expire on the same tick.

## Timing
- Cycle after `start` sampled: `busy` = 1 and `remaining` = `load_val`.
- Expiry latency for load N ≥ 1: the N-th `tick` after `start`. `done` rises in the cycle after that tick is high, which is (N-1)·TICK_DIV+2 to N·TICK_DIV+1 cycles after `start`, depending on prescaler phase.
- Periodic mode: `done` pulses are spaced exactly N·TICK_DIV cycles apart.
- `stop`: `busy` = 0 and `remaining` = 0 on the next cycle.
- Reset asserted mid-count: all outputs go to their reset values immediately, asynchronously. After release the prescaler restarts from 0.

## Test plan
All scenarios use TICK_DIV = 4, CH = 4, CNT_W = 8.
1. Reset, then observe: `tick` pulses every 4 cycles. `busy`, `done` and `remaining` stay 0 with no starts.
2. Channel 0, one-shot, load 3: `remaining` steps 3→2→1→0 on successive ticks. One `done` pulse on the 3rd tick, then `busy` = 0. No further `done`.
3. Channel 1, periodic, load 2: `done` pulses every 8 cycles for at least 4 periods. `busy` stays 1 and `remaining` alternates 2,1.
4. Channel 2, load 5, `stop` after 2 ticks: `busy` and `remaining` drop to 0 on the next cycle and `done` never pulses. `start` and `stop` asserted together: `stop` wins.
5. Channel 3, load 0: `done` pulses in the cycle after `start` and `busy` stays 0. Restart of channel 0 in the same cycle as its expiring tick: no `done`, `remaining` reloads.
6. All four channels started with load 1 in the same cycle: all four `done` bits pulse in the same cycle. Assert `rst_n` = 0 mid-count on a periodic channel: all outputs clear asynchronously.

Source files
------------

// File: rtl/temporizador_multi.sv
// Multi-channel countdown timer: one shared prescaler produces a base tick that
// CH independent one-shot/periodic channels count down from a latched load value.
module temporizador_multi #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CH       = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       start,
  input  logic [CH-1:0]       stop,
  input  logic [CH-1:0]       periodic,
  input  logic [CH*CNT_W-1:0] load_val,
  output logic                tick,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       done,
  output logic [CH*CNT_W-1:0] remaining
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  logic [PW-1:0]    r_presc;
  logic             r_tick;
  logic             w_presc_wrap;

  state_e           r_state     [CH];
  state_e           w_state_nxt [CH];
  logic [CNT_W-1:0] r_rem       [CH];
  logic [CNT_W-1:0] w_rem_nxt   [CH];
  logic [CNT_W-1:0] r_rel       [CH];
  logic [CNT_W-1:0] w_rel_nxt   [CH];
  logic [CH-1:0]    r_per;
  logic [CH-1:0]    w_per_nxt;
  logic [CH-1:0]    r_done;
  logic [CH-1:0]    w_done_nxt;

  assign w_presc_wrap = (r_presc == PW'(TICK_DIV - 1));

  // Free-running prescaler; tick is high the cycle after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
      r_tick  <= w_presc_wrap;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CH); i++) begin
        r_state[i] <= S_IDLE;
        r_rem[i]   <= '0;
        r_rel[i]   <= '0;
      end
      r_per  <= '0;
      r_done <= '0;
    end else begin
      for (int i = 0; i < int'(CH); i++) begin
        r_state[i] <= w_state_nxt[i];
        r_rem[i]   <= w_rem_nxt[i];
        r_rel[i]   <= w_rel_nxt[i];
      end
      r_per  <= w_per_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Per-channel next state: stop > start(0) > start(N) > tick countdown > hold.
  always_comb begin
    w_per_nxt  = r_per;
    w_done_nxt = '0;
    for (int i = 0; i < int'(CH); i++) begin
      w_state_nxt[i] = r_state[i];
      w_rem_nxt[i]   = r_rem[i];
      w_rel_nxt[i]   = r_rel[i];
      if (stop[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_rem_nxt[i]   = '0;
      end else if (start[i] && (load_val[i*CNT_W +: CNT_W] == '0)) begin
        w_state_nxt[i] = S_IDLE;
        w_rem_nxt[i]   = '0;
        w_done_nxt[i]  = 1'b1;
      end else if (start[i]) begin
        w_state_nxt[i] = S_RUN;
        w_rem_nxt[i]   = load_val[i*CNT_W +: CNT_W];
        w_rel_nxt[i]   = load_val[i*CNT_W +: CNT_W];
        w_per_nxt[i]   = periodic[i];
      end else if ((r_state[i] == S_RUN) && r_tick) begin
        if (r_rem[i] > CNT_W'(1)) begin
          w_rem_nxt[i] = r_rem[i] - CNT_W'(1);
        end else begin
          w_done_nxt[i] = 1'b1;
          if (r_per[i]) begin
            w_rem_nxt[i] = r_rel[i];
          end else begin
            w_state_nxt[i] = S_IDLE;
            w_rem_nxt[i]   = '0;
          end
        end
      end
    end
  end

  assign tick = r_tick;
  assign done = r_done;

  for (genvar g = 0; g < int'(CH); g++) begin : g_out
    assign busy[g]                     = (r_state[g] == S_RUN);
    assign remaining[g*CNT_W +: CNT_W] = r_rem[g];
  end

endmodule

// File: tb/tb_temporizador_multi.sv
// Scoreboard bench for temporizador_multi: directed scenarios plus random traffic
// checked against a per-cycle behavioural model with an expected-done queue.
module tb_temporizador_multi;

  localparam int unsigned TD = 4;
  localparam int unsigned CH = 4;
  localparam int unsigned CW = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [CH-1:0]      start = '0;
  logic [CH-1:0]      stop = '0;
  logic [CH-1:0]      periodic = '0;
  logic [CH*CW-1:0]   load_val = '0;
  logic               tick;
  logic [CH-1:0]      busy;
  logic [CH-1:0]      done;
  logic [CH*CW-1:0]   remaining;

  temporizador_multi #(.TICK_DIV(TD), .CH(CH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .periodic(periodic),
    .load_val(load_val), .tick(tick), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] mask;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  k       = 0;

  // Behavioural model: plain integers per channel, tick derived from cycle index.
  int  m_cnt [CH];
  int  m_rel [CH];
  bit  m_run [CH];
  bit  m_per [CH];
  bit  m_tick;

  function automatic void check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, k, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < int'(CH); i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 0; m_per[i] = 0;
    end
    m_tick = 0;
    exp_q.delete();
  endfunction

  task automatic step(input logic [CH-1:0] st, input logic [CH-1:0] sp,
                      input logic [CH-1:0] pe, input logic [CH*CW-1:0] lv);
    logic [CH-1:0] dm;
    int            l;
    @(negedge clk);
    k++;
    start = st; stop = sp; periodic = pe; load_val = lv;
    dm = '0;
    for (int i = 0; i < int'(CH); i++) begin
      l = int'(lv[i*CW +: CW]);
      if (sp[i]) begin
        m_run[i] = 0; m_cnt[i] = 0;
      end else if (st[i] && l == 0) begin
        m_run[i] = 0; m_cnt[i] = 0; dm[i] = 1'b1;
      end else if (st[i]) begin
        m_run[i] = 1; m_cnt[i] = l; m_rel[i] = l; m_per[i] = pe[i];
      end else if (m_run[i] && m_tick) begin
        if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
        else begin
          dm[i] = 1'b1;
          if (m_per[i]) m_cnt[i] = m_rel[i];
          else begin m_cnt[i] = 0; m_run[i] = 0; end
        end
      end
    end
    m_tick = (k % int'(TD) == 0);
    if (dm != '0) exp_q.push_back('{cyc: k, mask: dm});
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"}, tick, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_remaining"}, remaining, 0);
  endtask

  // Asynchronous reset mid-run; release just after a rising edge.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_clear();
    start = '0; stop = '0; periodic = '0; load_val = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("held_rst");
    #1 rst_n = 1'b1;
    k = 0;
  endtask

  // Monitor: compare outputs to the model and pop expected done events.
  always @(posedge clk) begin
    #1;
    if (rst_n && k > 0) begin
      check("tick", tick, m_tick);
      for (int i = 0; i < int'(CH); i++) begin
        check($sformatf("busy%0d", i), busy[i], m_run[i]);
        check($sformatf("remaining%0d", i), remaining[i*CW +: CW], m_cnt[i]);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < k) begin
        check("done_missed", 0, exp_q[0].mask);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == k) begin
        check("done", done, exp_q[0].mask);
        void'(exp_q.pop_front());
      end else if (done != '0) begin
        check("done_unexpected", done, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0]    rs, rp, re;
    logic [CH*CW-1:0] rl;
    int               guard;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    k = 0;

    idle(12);                                            // free-running tick, no activity
    step(4'b0001, '0, '0, {8'd0, 8'd0, 8'd0, 8'd3});     // ch0 one-shot 3
    idle(18);
    step(4'b0010, '0, 4'b0010, {8'd0, 8'd0, 8'd2, 8'd0}); // ch1 periodic 2
    idle(40);
    step('0, 4'b0010, '0, '0);
    step(4'b0100, '0, '0, {8'd0, 8'd5, 8'd0, 8'd0});     // ch2 load 5, stopped mid-run
    idle(9);
    step('0, 4'b0100, '0, '0);
    idle(3);
    step(4'b0100, 4'b0100, '0, {8'd0, 8'd5, 8'd0, 8'd0}); // start and stop together
    idle(4);
    step(4'b1000, '0, '0, '0);                           // ch3 load 0: immediate done
    idle(3);
    step(4'b0001, '0, '0, {8'd0, 8'd0, 8'd0, 8'd2});     // ch0 restart on expiring tick
    guard = 0;
    while (!(m_run[0] && m_cnt[0] == 1 && m_tick) && guard < 20) begin
      idle(1);
      guard++;
    end
    check("restart_window_found", guard < 20, 1);
    step(4'b0001, '0, '0, {8'd0, 8'd0, 8'd0, 8'd4});
    check("restart_no_done_queued", exp_q.size(), 0);
    idle(20);
    step(4'b1111, '0, '0, {8'd1, 8'd1, 8'd1, 8'd1});     // all channels expire together
    idle(8);
    step(4'b0010, '0, 4'b0010, {8'd0, 8'd0, 8'd3, 8'd0});
    idle(7);
    do_reset();
    idle(10);

    repeat (600) begin
      for (int i = 0; i < int'(CH); i++) begin
        rs[i] = ($urandom_range(15) == 0);
        rp[i] = ($urandom_range(31) == 0);
        re[i] = 1'($urandom_range(1));
        rl[i*CW +: CW] = 8'($urandom_range(6));
      end
      step(rs, rp, re, rl);
    end

    step('0, '1, '0, '0);
    idle(3);
    @(posedge clk);
    #2 check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
